mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_wb_reg.sv | 43 ++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory pipeline stage: datapath width, destination index width,
// default data-memory base address, and the byte-to-word address helper.
package mem_stage_pkg;

   localparam int REGISTER_FILE_LEN = 32;
   localparam int DEST_W            = 4;
   localparam int BASE_ADDR_DEFAULT = 1024;

   // Word offset from the data-memory base; the caller truncates to its word-address width.
   function automatic logic [REGISTER_FILE_LEN-1:0] byte_to_word(
      input logic [REGISTER_FILE_LEN-1:0] byte_addr,
      input logic [REGISTER_FILE_LEN-1:0] base
   );
      logic [REGISTER_FILE_LEN-1:0] offset;
      offset = byte_addr - base;
      return offset >> 2;
   endfunction

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: loads every cycle; a bubble clears the whole record.
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bubble,
   input  logic                         wb_en_d,
   input  logic                         mem_r_en_d,
   input  logic [REGISTER_FILE_LEN-1:0] alu_res_d,
   input  logic [REGISTER_FILE_LEN-1:0] mem_data_d,
   input  logic [DEST_W-1:0]            dest_d,
   output logic                         wb_en_out,
   output logic                         mem_r_en_out,
   output logic [REGISTER_FILE_LEN-1:0] alu_res_out,
   output logic [REGISTER_FILE_LEN-1:0] mem_data_out,
   output logic [DEST_W-1:0]            dest_out
);

   // Output record register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_out    <= 1'b0;
         mem_r_en_out <= 1'b0;
         alu_res_out  <= '0;
         mem_data_out <= '0;
         dest_out     <= '0;
      end else if (bubble) begin
         wb_en_out    <= 1'b0;
         mem_r_en_out <= 1'b0;
         alu_res_out  <= '0;
         mem_data_out <= '0;
         dest_out     <= '0;
      end else begin
         wb_en_out    <= wb_en_d;
         mem_r_en_out <= mem_r_en_d;
         alu_res_out  <= alu_res_d;
         mem_data_out <= mem_data_d;
         dest_out     <= dest_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store and stalls the
// upstream pipeline until the memory answers; non-memory ops pass through in one cycle.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int WORD_ADDR_W = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wb_en_in,
   input  logic                         mem_r_en_in,
   input  logic                         mem_w_en_in,
   input  logic [REGISTER_FILE_LEN-1:0] alu_res_in,
   input  logic [REGISTER_FILE_LEN-1:0] val_r_m_in,
   input  logic [DEST_W-1:0]            dest_in,
   output logic                         mem_req,
   output logic                         mem_we,
   input  logic                         mem_ready,
   output logic [WORD_ADDR_W-1:0]       mem_addr,
   output logic [REGISTER_FILE_LEN-1:0] mem_wdata,
   input  logic [REGISTER_FILE_LEN-1:0] mem_rdata,
   output logic                         freeze,
   output logic                         wb_en_out,
   output logic                         mem_r_en_out,
   output logic [REGISTER_FILE_LEN-1:0] alu_res_out,
   output logic [REGISTER_FILE_LEN-1:0] mem_data_out,
   output logic [DEST_W-1:0]            dest_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                       state;
   logic                         cmd_we;
   logic                         cmd_r_en;
   logic                         cmd_wb_en;
   logic [WORD_ADDR_W-1:0]       cmd_addr;
   logic [REGISTER_FILE_LEN-1:0] cmd_wdata;
   logic [REGISTER_FILE_LEN-1:0] cmd_alu_res;
   logic [DEST_W-1:0]            cmd_dest;
   logic [REGISTER_FILE_LEN-1:0] rdata_hold;

   logic                         access;
   logic [WORD_ADDR_W-1:0]       word_addr;
   logic                         bubble;
   logic                         wb_en_d;
   logic                         mem_r_en_d;
   logic [REGISTER_FILE_LEN-1:0] alu_res_d;
   logic [REGISTER_FILE_LEN-1:0] mem_data_d;
   logic [DEST_W-1:0]            dest_d;

   assign access    = mem_r_en_in | mem_w_en_in;
   assign word_addr = WORD_ADDR_W'(byte_to_word(alu_res_in, REGISTER_FILE_LEN'(BASE_ADDR)));

   // Access sequencer: latch the command in IDLE, wait for mem_ready in BUSY, retire in DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cmd_we      <= 1'b0;
         cmd_r_en    <= 1'b0;
         cmd_wb_en   <= 1'b0;
         cmd_addr    <= '0;
         cmd_wdata   <= '0;
         cmd_alu_res <= '0;
         cmd_dest    <= '0;
         rdata_hold  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  cmd_we      <= mem_w_en_in;
                  // A combined read+write request performs only the write
                  cmd_r_en    <= mem_r_en_in & ~mem_w_en_in;
                  cmd_wb_en   <= wb_en_in;
                  cmd_addr    <= word_addr;
                  cmd_wdata   <= val_r_m_in;
                  cmd_alu_res <= alu_res_in;
                  cmd_dest    <= dest_in;
                  state       <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  if (cmd_r_en) begin
                     rdata_hold <= mem_rdata;
                  end else begin
                     rdata_hold <= '0;
                  end
                  state <= DONE;
               end else begin
                  state <= BUSY;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stall request and MEM/WB next-record selection
   always_comb begin
      freeze     = 1'b0;
      bubble     = 1'b1;
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      alu_res_d  = '0;
      mem_data_d = '0;
      dest_d     = '0;
      case (state)
         IDLE: begin
            if (access) begin
               freeze = rst;
            end else begin
               bubble     = 1'b0;
               wb_en_d    = wb_en_in;
               mem_r_en_d = mem_r_en_in;
               alu_res_d  = alu_res_in;
               dest_d     = dest_in;
            end
         end
         BUSY: freeze = 1'b1;
         DONE: begin
            bubble     = 1'b0;
            wb_en_d    = cmd_wb_en;
            mem_r_en_d = cmd_r_en;
            alu_res_d  = cmd_alu_res;
            mem_data_d = cmd_r_en ? rdata_hold : '0;
            dest_d     = cmd_dest;
         end
         default: freeze = 1'b0;
      endcase
   end

   assign mem_req   = (state == BUSY);
   assign mem_we    = (state == BUSY) & cmd_we;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

   mem_wb_reg u_mem_wb_reg (
      .clk          (clk),
      .rst          (rst),
      .bubble       (bubble),
      .wb_en_d      (wb_en_d),
      .mem_r_en_d   (mem_r_en_d),
      .alu_res_d    (alu_res_d),
      .mem_data_d   (mem_data_d),
      .dest_d       (dest_d),
      .wb_en_out    (wb_en_out),
      .mem_r_en_out (mem_r_en_out),
      .alu_res_out  (alu_res_out),
      .mem_data_out (mem_data_out),
      .dest_out     (dest_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single accesses run back to back,
// plus hand sequences for reset behaviour and reset in the middle of an access.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [REGISTER_FILE_LEN-1:0] alu_res_in, val_r_m_in;
   logic [DEST_W-1:0]            dest_in;
   logic                         mem_req, mem_we, mem_ready;
   logic [5:0]                   mem_addr;
   logic [REGISTER_FILE_LEN-1:0] mem_wdata, mem_rdata;
   logic                         freeze;
   logic                         wb_en_out, mem_r_en_out;
   logic [REGISTER_FILE_LEN-1:0] alu_res_out, mem_data_out;
   logic [DEST_W-1:0]            dest_out;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in), .dest_in(dest_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .freeze(freeze),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb, r, w;
      logic [31:0] alu, val, rdata;
      logic [3:0]  dest;
      int          waits;
      logic [5:0]  addr;
      int          frz;
      logic        r_out;
      logic [31:0] data;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
      wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
      alu_res_in = alu; val_r_m_in = val; dest_in = dest;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int frz = 0, reqc = 0, wec = 0, busy = 0;
      bit seen = 0;
      bit acc;
      acc = v.r | v.w;
      @(negedge clk);
      drive(v.wb, v.r, v.w, v.alu, v.val, v.dest);
      mem_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (freeze) frz++;
         if (mem_we) wec++;
         if (mem_req) begin
            reqc++;
            if (!seen) begin
               seen = 1;
               check($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.addr));
               check($sformatf("v%0d mem_wdata", idx), 64'(mem_wdata), 64'(v.val));
               check($sformatf("v%0d bubble wb_en_out", idx), 64'(wb_en_out), 64'd0);
            end
            mem_ready = (busy == v.waits);
            mem_rdata = v.rdata;
            busy++;
         end else begin
            mem_ready = 1'b0;
         end
         if (!freeze) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      check($sformatf("v%0d freeze cycles", idx), 64'(frz), 64'(v.frz));
      check($sformatf("v%0d req cycles", idx), 64'(reqc), acc ? 64'(v.waits + 1) : 64'd0);
      check($sformatf("v%0d we cycles", idx), 64'(wec), v.w ? 64'(v.waits + 1) : 64'd0);
      check($sformatf("v%0d no retrigger", idx), 64'(mem_req), 64'd0);
      check($sformatf("v%0d wb_en_out", idx), 64'(wb_en_out), 64'(v.wb));
      check($sformatf("v%0d mem_r_en_out", idx), 64'(mem_r_en_out), 64'(v.r_out));
      check($sformatf("v%0d alu_res_out", idx), 64'(alu_res_out), 64'(v.alu));
      check($sformatf("v%0d mem_data_out", idx), 64'(mem_data_out), 64'(v.data));
      check($sformatf("v%0d dest_out", idx), 64'(dest_out), 64'(v.dest));
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   vec_t vecs[8];

   initial begin
      //          wb    r     w     alu       val         rdata        dest  wt addr  frz r_out data
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h5,    32'h0,      32'h0,       4'd3, 0, 6'd0,  0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD,   32'h0,       4'd0, 0, 6'd2,  2, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'h0,      32'h1234,    4'd5, 3, 6'd1,  5, 1'b1, 32'h1234};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'd1284, 32'h0,      32'hCAFE,    4'd7, 0, 6'd1,  2, 1'b1, 32'hCAFE};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd1027, 32'h0,      32'hBEEF,    4'd2, 1, 6'd0,  3, 1'b1, 32'hBEEF};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 32'd1100, 32'h55AA,   32'h9999,    4'd9, 0, 6'd19, 2, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0,       4'd15,0, 6'd0,  0, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 32'd1020, 32'h0,      32'h1,       4'd1, 0, 6'd63, 2, 1'b1, 32'h1};

      rst = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEAD, 4'd3);
      repeat (2) @(negedge clk);
      #1;
      check("reset freeze", 64'(freeze), 64'd0);
      check("reset mem_req", 64'(mem_req), 64'd0);
      check("reset mem_we", 64'(mem_we), 64'd0);
      check("reset mem_addr", 64'(mem_addr), 64'd0);
      check("reset wb_en_out", 64'(wb_en_out), 64'd0);
      check("reset alu_res_out", 64'(alu_res_out), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst = 1'b1;

      // Table vectors run back to back: each access starts the cycle after the previous DONE
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset pulse in the middle of a store
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'd1036, 32'h1111, 4'd4);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("mid busy mem_req", 64'(mem_req), 64'd1);
      check("mid busy mem_addr", 64'(mem_addr), 64'd3);
      rst = 1'b0;
      #1;
      check("rst busy freeze", 64'(freeze), 64'd0);
      check("rst busy mem_req", 64'(mem_req), 64'd0);
      check("rst busy mem_we", 64'(mem_we), 64'd0);
      check("rst busy mem_addr", 64'(mem_addr), 64'd0);
      check("rst busy mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst busy dest_out", 64'(dest_out), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      check("late ready mem_req", 64'(mem_req), 64'd0);
      check("late ready mem_we", 64'(mem_we), 64'd0);
      check("late ready freeze", 64'(freeze), 64'd0);
      check("late ready wb_en_out", 64'(wb_en_out), 64'd0);
      mem_ready = 1'b0;

      // Clean load after reset, then a store directly behind it
      run_vec('{1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 32'hA5A5, 4'd6, 2, 6'd4, 4, 1'b1, 32'hA5A5}, 8);
      run_vec('{1'b0, 1'b0, 1'b1, 32'd1044, 32'h7777, 32'h0, 4'd0, 1, 6'd5, 3, 1'b0, 32'h0}, 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
